// File: rtl/ahb_lite_pipe_master_if.sv
// Bundles the command, AHB-Lite bus and response signals of the pipelined master.
// The master modport is the DUT view; the slave modport is the bus/command partner view.
interface ahb_lite_pipe_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [2:0]        cmd_size;
    logic [DATA_W-1:0] cmd_wdata;

    logic [ADDR_W-1:0] HADDR;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [3:0]        HPROT;
    logic [1:0]        HTRANS;
    logic              HMASTLOCK;
    logic [DATA_W-1:0] HWDATA;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADY;
    logic              HRESP;

    logic              rsp_valid;
    logic              rsp_write;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        input  HRDATA, HREADY, HRESP,
        output cmd_ready,
        output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
        output rsp_valid, rsp_write, rsp_err, rsp_rdata, busy
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        output HRDATA, HREADY, HRESP,
        input  cmd_ready,
        input  HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
        input  rsp_valid, rsp_write, rsp_err, rsp_rdata, busy
    );
endinterface

// File: rtl/ahb_lite_pipe_master.sv
// Pipelined AHB-Lite master: command FIFO -> address phase (_p0) -> data phase (_p1) -> response (_p2).
// Two-cycle ERROR responses suppress the pending address phase and reissue it as NONSEQ.
module ahb_lite_pipe_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic HCLK,
    input  logic HRESETn,
    ahb_lite_pipe_master_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [2:0]        size;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    cmd_t              mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic              full, empty, push, pop, hold_p0, load_p0;
    cmd_t              head;

    logic [1:0]        trans_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic              write_p0;
    logic [2:0]        size_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic              supp;

    logic              vld_p1, write_p1;
    logic [DATA_W-1:0] wdata_p1;

    logic              vld_p2, write_p2, err_p2;
    logic [DATA_W-1:0] rdata_p2;

    // Incrementing continuation of the previous transfer within the same 1KB page.
    function automatic logic is_seq(input logic prev_vld, input logic prev_write,
                                    input logic [2:0] prev_size,
                                    input logic [ADDR_W-1:0] prev_addr, input cmd_t nxt);
        logic [ADDR_W-1:0] incr;
        incr = ADDR_W'(1) << nxt.size;
        return prev_vld && (prev_write == nxt.write) && (prev_size == nxt.size) &&
               (nxt.addr == prev_addr + incr) &&
               (nxt.addr[ADDR_W-1:10] == prev_addr[ADDR_W-1:10]);
    endfunction

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign push    = bus.cmd_valid && !full;
    assign hold_p0 = supp && (trans_p0 != IDLE);
    assign load_p0 = bus.HREADY && !hold_p0;
    assign pop     = load_p0 && !empty;
    assign head    = mem[rd_ptr];

    // Command FIFO
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (push) mem[wr_ptr] <= '{write: bus.cmd_write, addr: bus.cmd_addr,
                                   size: bus.cmd_size, wdata: bus.cmd_wdata};
    end

    // Stage p0: address phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            trans_p0 <= IDLE;
            addr_p0  <= '0;
            write_p0 <= 1'b0;
            size_p0  <= '0;
            wdata_p0 <= '0;
        end else if (bus.HREADY) begin
            if (hold_p0) begin
                trans_p0 <= NONSEQ;
            end else if (!empty) begin
                trans_p0 <= is_seq((trans_p0 != IDLE) && !supp, write_p0, size_p0,
                                   addr_p0, head) ? SEQ : NONSEQ;
                addr_p0  <= head.addr;
                write_p0 <= head.write;
                size_p0  <= head.size;
                wdata_p0 <= head.wdata;
            end else begin
                trans_p0 <= IDLE;
            end
        end
    end

    // First cycle of an ERROR response: hide the next address phase until the slave is ready.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)                         supp <= 1'b0;
        else if (bus.HREADY)                  supp <= 1'b0;
        else if (vld_p1 && bus.HRESP)         supp <= 1'b1;
    end

    // Stage p1: data phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            vld_p1   <= 1'b0;
            write_p1 <= 1'b0;
            wdata_p1 <= '0;
        end else if (bus.HREADY) begin
            vld_p1   <= !supp && (trans_p0 != IDLE);
            write_p1 <= write_p0;
            wdata_p1 <= wdata_p0;
        end
    end

    // Stage p2: completion
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            vld_p2   <= 1'b0;
            write_p2 <= 1'b0;
            err_p2   <= 1'b0;
            rdata_p2 <= '0;
        end else begin
            vld_p2 <= bus.HREADY && vld_p1;
            if (bus.HREADY && vld_p1) begin
                write_p2 <= write_p1;
                err_p2   <= bus.HRESP;
                rdata_p2 <= write_p1 ? '0 : bus.HRDATA;
            end
        end
    end

    assign bus.cmd_ready = !full;
    assign bus.HTRANS    = supp ? IDLE : trans_p0;
    assign bus.HADDR     = addr_p0;
    assign bus.HWRITE    = write_p0;
    assign bus.HSIZE     = size_p0;
    assign bus.HBURST    = 3'b001;
    assign bus.HPROT     = 4'b0011;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.HWDATA    = wdata_p1;
    assign bus.rsp_valid = vld_p2;
    assign bus.rsp_write = write_p2;
    assign bus.rsp_err   = err_p2;
    assign bus.rsp_rdata = rdata_p2;
    assign bus.busy      = !empty || (trans_p0 != IDLE) || vld_p1 || supp;
endmodule

// File: tb/tb_ahb_lite_pipe_master.sv
// Directed bench for ahb_lite_pipe_master: bus timing checked inline, responses via a scoreboard queue.
module tb_ahb_lite_pipe_master;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    typedef struct {
        logic        write;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic HCLK = 1'b0;
    logic HRESETn;
    int   errors = 0;
    int   checks = 0;
    rsp_t exp_q[$];

    ahb_lite_pipe_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ahb_lite_pipe_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    task automatic drive(input logic v, input logic w, input logic [31:0] a,
                         input logic [2:0] s, input logic [31:0] d);
        bus.cmd_valid = v;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_size  = s;
        bus.cmd_wdata = d;
    endtask

    task automatic expect_rsp(input logic w, input logic e, input logic [31:0] d);
        rsp_t r;
        r.write = w;
        r.err   = e;
        r.rdata = d;
        exp_q.push_back(r);
    endtask

    task automatic drain(input string name);
        int n = 0;
        bus.cmd_valid = 1'b0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check(name, exp_q.size(), 0);
        tick();
        tick();
    endtask

    // Response monitor
    always @(negedge HCLK) begin
        if (HRESETn === 1'b1 && bus.rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                rsp_t r;
                r = exp_q.pop_front();
                check("rsp_write", bus.rsp_write, r.write);
                check("rsp_err",   bus.rsp_err,   r.err);
                check("rsp_rdata", bus.rsp_rdata, r.rdata);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] wd [4];
        int   idx;
        int   n;
        logic rdy;
        wd[0] = 32'h11111111; wd[1] = 32'h22222222;
        wd[2] = 32'h33333333; wd[3] = 32'h44444444;

        HRESETn    = 1'b0;
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = '0;
        drive(0, 0, 0, 0, 0);
        @(negedge HCLK);
        check("rst_htrans",    bus.HTRANS,    0);
        check("rst_haddr",     bus.HADDR,     0);
        check("rst_hwrite",    bus.HWRITE,    0);
        check("rst_hsize",     bus.HSIZE,     0);
        check("rst_hwdata",    bus.HWDATA,    0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_err",   bus.rsp_err,   0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_busy",      bus.busy,      0);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        tick();
        HRESETn = 1'b1;
        tick();

        // Single read
        bus.HRDATA = 32'hCAFE0100;
        drive(1, 0, 32'h100, 3'd2, 0);
        expect_rsp(0, 0, 32'hCAFE0100);
        check("t1_cmd_ready", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        check("t1_idle_after_accept", bus.HTRANS, 2'b00);
        tick();
        check("t1_htrans",    bus.HTRANS,    2'b10);
        check("t1_haddr",     bus.HADDR,     32'h100);
        check("t1_hwrite",    bus.HWRITE,    0);
        check("t1_hsize",     bus.HSIZE,     2);
        check("t1_hburst",    bus.HBURST,    3'b001);
        check("t1_hprot",     bus.HPROT,     4'b0011);
        check("t1_hmastlock", bus.HMASTLOCK, 0);
        check("t1_busy",      bus.busy,      1);
        tick();
        check("t1_rsp_early", bus.rsp_valid, 0);
        tick();
        check("t1_rsp_valid", bus.rsp_valid, 1);
        drain("t1_drain");
        check("t1_idle_busy", bus.busy, 0);

        // Four back-to-back incrementing writes
        for (int k = 0; k < 7; k++) begin
            if (k < 4) begin
                drive(1, 1, 32'h200 + 32'(4 * k), 3'd2, wd[k]);
                expect_rsp(1, 0, 0);
            end else begin
                bus.cmd_valid = 1'b0;
            end
            tick();
            if (k >= 1 && k <= 4) begin
                check($sformatf("t2_htrans%0d", k - 1), bus.HTRANS, (k == 1) ? 2'b10 : 2'b11);
                check($sformatf("t2_haddr%0d", k - 1),  bus.HADDR,  32'h200 + 32'(4 * (k - 1)));
            end
            if (k >= 2 && k <= 5)
                check($sformatf("t2_hwdata%0d", k - 2), bus.HWDATA, wd[k - 2]);
        end
        drain("t2_drain");

        // 1KB boundary crossing
        drive(1, 1, 32'h3FC, 3'd2, 32'h000003FC); expect_rsp(1, 0, 0);
        tick();
        drive(1, 1, 32'h400, 3'd2, 32'h00000400); expect_rsp(1, 0, 0);
        tick();
        bus.cmd_valid = 1'b0;
        check("t3_htrans_first", bus.HTRANS, 2'b10);
        check("t3_haddr_first",  bus.HADDR,  32'h3FC);
        tick();
        check("t3_htrans_cross", bus.HTRANS, 2'b10);
        check("t3_haddr_cross",  bus.HADDR,  32'h400);
        drain("t3_drain");

        // Wait states on a read while a write sits in the address phase
        for (int k = 0; k < 9; k++) begin
            case (k)
                0: begin drive(1, 1, 32'h600, 3'd2, 32'hA5A5A5A5); expect_rsp(1, 0, 0); end
                1: begin drive(1, 0, 32'h700, 3'd2, 32'h0);        expect_rsp(0, 0, 32'h70070000); end
                2: begin drive(1, 1, 32'h800, 3'd2, 32'h5A5A5A5A); expect_rsp(1, 0, 0); end
                default: bus.cmd_valid = 1'b0;
            endcase
            bus.HREADY = !(k >= 4 && k <= 6);
            bus.HRDATA = (k == 7) ? 32'h70070000 : 32'hDEADBEEF;
            tick();
            if (k == 2) begin
                check("t4_hwdata_a", bus.HWDATA, 32'hA5A5A5A5);
                check("t4_haddr_b",  bus.HADDR,  32'h700);
            end
            if (k >= 3 && k <= 6) begin
                check($sformatf("t4_htrans_w%0d", k), bus.HTRANS, 2'b10);
                check($sformatf("t4_haddr_w%0d", k),  bus.HADDR,  32'h800);
                check($sformatf("t4_hwrite_w%0d", k), bus.HWRITE, 1);
                check($sformatf("t4_hwdata_w%0d", k), bus.HWDATA, 0);
            end
            if (k >= 4 && k <= 6)
                check($sformatf("t4_rsp_hold%0d", k), bus.rsp_valid, 0);
            if (k == 7) begin
                check("t4_htrans_done", bus.HTRANS,    2'b00);
                check("t4_hwdata_c",    bus.HWDATA,    32'h5A5A5A5A);
                check("t4_rsp_read",    bus.rsp_valid, 1);
            end
        end
        bus.HREADY = 1'b1;
        drain("t4_drain");

        // ERROR response on the first of two reads
        for (int k = 0; k < 8; k++) begin
            case (k)
                0: begin drive(1, 0, 32'h900, 3'd2, 0); expect_rsp(0, 1, 32'hE0E0E0E0); end
                1: begin drive(1, 0, 32'h904, 3'd2, 0); expect_rsp(0, 0, 32'h12345904); end
                default: bus.cmd_valid = 1'b0;
            endcase
            bus.HREADY = (k != 3);
            bus.HRESP  = (k == 3 || k == 4);
            bus.HRDATA = (k == 4) ? 32'hE0E0E0E0 : ((k == 6) ? 32'h12345904 : 32'h0);
            tick();
            case (k)
                2: begin
                    check("t5_htrans_seq", bus.HTRANS, 2'b11);
                    check("t5_haddr_seq",  bus.HADDR,  32'h904);
                end
                3: begin
                    check("t5_htrans_supp", bus.HTRANS,    2'b00);
                    check("t5_haddr_held",  bus.HADDR,     32'h904);
                    check("t5_busy_supp",   bus.busy,      1);
                    check("t5_rsp_none",    bus.rsp_valid, 0);
                end
                4: begin
                    check("t5_htrans_reissue", bus.HTRANS,    2'b10);
                    check("t5_haddr_reissue",  bus.HADDR,     32'h904);
                    check("t5_rsp_err_valid",  bus.rsp_valid, 1);
                end
                5: check("t5_htrans_after", bus.HTRANS, 2'b00);
                6: check("t5_rsp_ok_valid", bus.rsp_valid, 1);
                default: ;
            endcase
        end
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        drain("t5_drain");

        // FIFO fill with the slave stalled
        idx = 0;
        for (int k = 0; k < 6; k++) begin
            bus.HREADY = 1'b0;
            drive(1, 1, 32'hA00 + 32'(4 * idx), 3'd2, 32'hA0 + 32'(idx));
            rdy = bus.cmd_ready;
            tick();
            if (rdy) begin
                expect_rsp(1, 0, 0);
                idx++;
            end
        end
        check("t6_accepted_full", idx, DEPTH);
        check("t6_cmd_ready_low", bus.cmd_ready, 0);
        check("t6_htrans_stall",  bus.HTRANS,    2'b00);
        bus.HREADY = 1'b1;
        n = 0;
        while (idx < DEPTH + 2 && n < 40) begin
            drive(1, 1, 32'hA00 + 32'(4 * idx), 3'd2, 32'hA0 + 32'(idx));
            rdy = bus.cmd_ready;
            tick();
            if (rdy) begin
                expect_rsp(1, 0, 0);
                idx++;
            end
            n++;
        end
        bus.cmd_valid = 1'b0;
        check("t6_accepted_all", idx, DEPTH + 2);
        drain("t6_drain");

        // Reset asserted mid-stream
        bus.HRDATA = 32'hBBBB0000;
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 32'hB00 + 32'(4 * k), 3'd2, 0);
            expect_rsp(0, 0, 32'hBBBB0000);
            tick();
        end
        bus.cmd_valid = 1'b0;
        check("t7_busy_before", bus.busy, 1);
        #2;
        HRESETn = 1'b0;
        exp_q.delete();
        #1;
        check("t7_htrans",    bus.HTRANS,    0);
        check("t7_haddr",     bus.HADDR,     0);
        check("t7_hwrite",    bus.HWRITE,    0);
        check("t7_hsize",     bus.HSIZE,     0);
        check("t7_hwdata",    bus.HWDATA,    0);
        check("t7_rsp_valid", bus.rsp_valid, 0);
        check("t7_rsp_rdata", bus.rsp_rdata, 0);
        check("t7_busy",      bus.busy,      0);
        check("t7_cmd_ready", bus.cmd_ready, 1);
        @(negedge HCLK);
        tick();
        HRESETn = 1'b1;
        tick();
        bus.HRDATA = 32'h0C00C00C;
        drive(1, 0, 32'hC00, 3'd2, 0);
        expect_rsp(0, 0, 32'h0C00C00C);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        check("t7_first_nonseq", bus.HTRANS, 2'b10);
        check("t7_first_haddr",  bus.HADDR,  32'hC00);
        drain("t7_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
